dmem_responder: RTL and testbench

Data-port memory responder for the LC3b pipeline. It answers the single-outstanding read/write requests that the datapath and its LDI/STI stall sequencer issue on the data memory port, and returns a one-cycle `mem_resp` after a parameterized latency. Backing storage is an internal word array. The block is the memory-side end of the `mem_read`/`mem_write`/`mem_resp` handshake and replaces the ideal-memory stub on port b.

---
 rtl/dmem_responder.sv | 101 ++++++++++
 tb/tb_dmem_responder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-port memory responder for the LC3b pipeline
// Answers one outstanding read/write on the mem_read/mem_write/mem_resp handshake after LATENCY cycles.
module dmem_responder #(
   parameter int ADDR_W  = 8,
   parameter int LATENCY = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [15:0] mem_address,
   input  logic [15:0] mem_wdata,
   input  logic [1:0]  mem_byte_enable,
   output logic        mem_resp,
   output logic [15:0] mem_rdata,
   output logic        busy,
   output logic        conflict
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam logic [3:0] LOAD_CNT = 4'(LATENCY - 1);

   state_t              r_state;
   state_t              w_next;
   logic [3:0]          r_cnt;
   logic                r_is_write;
   logic [ADDR_W-1:0]   r_idx;
   logic [15:0]         r_wdata;
   logic [1:0]          r_be;
   logic [15:0]         r_rdata;
   logic                r_conflict;
   logic [15:0]         r_mem [0:(1<<ADDR_W)-1];

   logic                w_req;
   logic                w_accept;
   logic                w_is_write;
   logic [ADDR_W-1:0]   w_idx;
   logic                w_unused;

   assign w_req    = mem_read | mem_write;
   assign w_accept = (r_state == IDLE) && w_req;
   assign w_unused = ^{mem_address[0], mem_address >> (ADDR_W + 1)};

   // With LATENCY==1 the read happens on the accepting edge, so use the live request fields there.
   assign w_idx      = (r_state == IDLE) ? mem_address[ADDR_W:1] : r_idx;
   assign w_is_write = (r_state == IDLE) ? mem_write : r_is_write;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: if (w_req) w_next = (LATENCY == 1) ? RESP : WAIT;
         WAIT: begin
            if (!w_req)          w_next = IDLE;
            else if (r_cnt <= 1) w_next = RESP;
         end
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_cnt      <= 4'd0;
         r_is_write <= 1'b0;
         r_idx      <= '0;
         r_wdata    <= 16'h0000;
         r_be       <= 2'b00;
         r_rdata    <= 16'h0000;
         r_conflict <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_is_write <= mem_write;
            r_idx      <= mem_address[ADDR_W:1];
            r_wdata    <= mem_wdata;
            r_be       <= mem_byte_enable;
            r_cnt      <= LOAD_CNT;
            if (mem_read && mem_write) r_conflict <= 1'b1;
         end else if (r_state == WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_next == RESP && !w_is_write) r_rdata <= r_mem[w_idx];
      end
   end

   // Storage has no reset; a write still pending in RESP is dropped when reset is high.
   always_ff @(posedge clk) begin
      if (!reset && r_state == RESP && r_is_write) begin
         if (r_be[1]) r_mem[r_idx][15:8] <= r_wdata[15:8];
         if (r_be[0]) r_mem[r_idx][7:0]  <= r_wdata[7:0];
      end
   end

   assign mem_resp  = (r_state == RESP);
   assign mem_rdata = r_rdata;
   assign busy      = (r_state != IDLE);
   assign conflict  = r_conflict;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder at LATENCY 3 and 1
module tb_dmem_responder;

   typedef struct {
      int          cyc;
      logic [15:0] rdata;
   } exp_t;

   logic        clk;
   int          cyc = 0;
   int          n_vec = 0;
   int          n_err = 0;
   exp_t        qa[$];
   exp_t        qb[$];
   exp_t        ea, eb;
   logic [15:0] last_rd [2];

   logic        a_reset, a_read, a_write, a_resp, a_busy, a_conflict;
   logic [15:0] a_addr, a_wdata, a_rdata;
   logic [1:0]  a_be;
   logic        b_reset, b_read, b_write, b_resp, b_busy, b_conflict;
   logic [15:0] b_addr, b_wdata, b_rdata;
   logic [1:0]  b_be;

   dmem_responder #(.ADDR_W(8), .LATENCY(3)) u_a (
      .clk(clk), .reset(a_reset), .mem_read(a_read), .mem_write(a_write),
      .mem_address(a_addr), .mem_wdata(a_wdata), .mem_byte_enable(a_be),
      .mem_resp(a_resp), .mem_rdata(a_rdata), .busy(a_busy), .conflict(a_conflict)
   );

   dmem_responder #(.ADDR_W(8), .LATENCY(1)) u_b (
      .clk(clk), .reset(b_reset), .mem_read(b_read), .mem_write(b_write),
      .mem_address(b_addr), .mem_wdata(b_wdata), .mem_byte_enable(b_be),
      .mem_resp(b_resp), .mem_rdata(b_rdata), .busy(b_busy), .conflict(b_conflict)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (a_resp) begin
         n_vec++;
         if (qa.size() == 0) begin
            n_err++;
            $display("FAIL a_resp_unexpected: pulse at cycle %0d, none required", cyc);
         end else begin
            ea = qa.pop_front();
            if (cyc != ea.cyc || a_rdata !== ea.rdata) begin
               n_err++;
               $display("FAIL a_resp: cycle %0d rdata %h, required cycle %0d rdata %h",
                        cyc, a_rdata, ea.cyc, ea.rdata);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (b_resp) begin
         n_vec++;
         if (qb.size() == 0) begin
            n_err++;
            $display("FAIL b_resp_unexpected: pulse at cycle %0d, none required", cyc);
         end else begin
            eb = qb.pop_front();
            if (cyc != eb.cyc || b_rdata !== eb.rdata) begin
               n_err++;
               $display("FAIL b_resp: cycle %0d rdata %h, required cycle %0d rdata %h",
                        cyc, b_rdata, eb.cyc, eb.rdata);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   function automatic int lat(input int d);
      return (d == 0) ? 3 : 1;
   endfunction

   task automatic set_req(input int d, input bit rd, input bit wr, input logic [15:0] addr,
                          input logic [15:0] wd, input logic [1:0] be);
      if (d == 0) begin
         a_read = rd; a_write = wr; a_addr = addr; a_wdata = wd; a_be = be;
      end else begin
         b_read = rd; b_write = wr; b_addr = addr; b_wdata = wd; b_be = be;
      end
   endtask

   // Issue a request in the current IDLE cycle and leave it held into the following IDLE cycle.
   task automatic req(input int d, input bit rd, input bit wr, input logic [15:0] addr,
                      input logic [15:0] wd, input logic [1:0] be, input logic [15:0] exp_rd);
      exp_t e;
      set_req(d, rd, wr, addr, wd, be);
      e.cyc = cyc + lat(d);
      if (!wr) last_rd[d] = exp_rd;
      e.rdata = last_rd[d];
      if (d == 0) qa.push_back(e); else qb.push_back(e);
      repeat (lat(d) + 1) @(posedge clk);
      #1;
   endtask

   task automatic drop(input int d);
      if (d == 0) begin a_read = 1'b0; a_write = 1'b0; end
      else        begin b_read = 1'b0; b_write = 1'b0; end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      a_reset = 1'b1; b_reset = 1'b1;
      set_req(0, 0, 0, 16'h0000, 16'h0000, 2'b00);
      set_req(1, 0, 0, 16'h0000, 16'h0000, 2'b00);
      last_rd[0] = 16'h0000; last_rd[1] = 16'h0000;
      repeat (2) @(posedge clk);
      #1;
      chk("a_reset_resp", {31'd0, a_resp}, 32'd0);
      chk("a_reset_busy", {31'd0, a_busy}, 32'd0);
      chk("a_reset_rdata", {16'd0, a_rdata}, 32'd0);
      chk("a_reset_conflict", {31'd0, a_conflict}, 32'd0);
      chk("b_reset_conflict", {31'd0, b_conflict}, 32'd0);
      a_reset = 1'b0; b_reset = 1'b0;
      @(posedge clk); #1;

      req(0, 0, 1, 16'h0030, 16'h1111, 2'b11, 16'h0000); drop(0);

      set_req(0, 1, 0, 16'h0030, 16'h0000, 2'b00);
      a_reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("rst_hold_resp", {31'd0, a_resp}, 32'd0);
         chk("rst_hold_busy", {31'd0, a_busy}, 32'd0);
         chk("rst_hold_rdata", {16'd0, a_rdata}, 32'd0);
         @(posedge clk); #1;
      end
      a_reset = 1'b0;
      qa.push_back('{cyc + 3, 16'h1111});
      last_rd[0] = 16'h1111;
      repeat (4) @(posedge clk); #1;
      drop(0);

      req(0, 0, 1, 16'h0010, 16'hBEEF, 2'b11, 16'h0000); drop(0);
      req(0, 1, 0, 16'h0010, 16'h0000, 2'b00, 16'hBEEF); drop(0);
      req(0, 1, 0, 16'h0011, 16'h0000, 2'b00, 16'hBEEF); drop(0);

      req(0, 0, 1, 16'h0020, 16'h1234, 2'b11, 16'h0000); drop(0);
      req(0, 0, 1, 16'h0020, 16'hABCD, 2'b10, 16'h0000); drop(0);
      req(0, 1, 0, 16'h0020, 16'h0000, 2'b00, 16'hAB34); drop(0);
      req(0, 0, 1, 16'h0020, 16'hFFFF, 2'b00, 16'h0000); drop(0);
      req(0, 1, 0, 16'h0020, 16'h0000, 2'b00, 16'hAB34); drop(0);
      req(0, 0, 1, 16'h0020, 16'h00EE, 2'b01, 16'h0000); drop(0);
      req(0, 1, 0, 16'h0020, 16'h0000, 2'b00, 16'hABEE); drop(0);

      req(0, 0, 1, 16'h0040, 16'h0080, 2'b11, 16'h0000); drop(0);
      req(0, 0, 1, 16'h0080, 16'h5A5A, 2'b11, 16'h0000); drop(0);
      req(0, 1, 0, 16'h0040, 16'h0000, 2'b00, 16'h0080);
      req(0, 1, 0, 16'h0080, 16'h0000, 2'b00, 16'h5A5A); drop(0);

      req(0, 0, 1, 16'h0060, 16'h2468, 2'b11, 16'h0000);
      req(0, 1, 0, 16'h0060, 16'h0000, 2'b00, 16'h2468); drop(0);

      req(0, 0, 1, 16'h0050, 16'h7777, 2'b11, 16'h0000); drop(0);
      set_req(0, 0, 1, 16'h0050, 16'h9999, 2'b11);
      repeat (2) begin @(posedge clk); #1; end
      drop(0);
      @(negedge clk);
      chk("abandon_busy", {31'd0, a_busy}, 32'd0);
      @(posedge clk); #1;
      req(0, 1, 0, 16'h0050, 16'h0000, 2'b00, 16'h7777); drop(0);

      set_req(0, 0, 1, 16'h0050, 16'hDEAD, 2'b11);
      qa.push_back('{cyc + 3, last_rd[0]});
      repeat (3) @(posedge clk); #1;
      a_reset = 1'b1; a_write = 1'b0;
      @(posedge clk); #1;
      a_reset = 1'b0;
      last_rd[0] = 16'h0000;
      @(negedge clk);
      chk("rst_abort_busy", {31'd0, a_busy}, 32'd0);
      chk("rst_abort_rdata", {16'd0, a_rdata}, 32'd0);
      @(posedge clk); #1;
      req(0, 1, 0, 16'h0050, 16'h0000, 2'b00, 16'h7777); drop(0);
      chk("a_conflict_clear", {31'd0, a_conflict}, 32'd0);

      req(1, 1, 1, 16'h0002, 16'h0F0F, 2'b11, 16'h0000); drop(1);
      chk("b_conflict_set", {31'd0, b_conflict}, 32'd1);
      req(1, 1, 0, 16'h0002, 16'h0000, 2'b00, 16'h0F0F); drop(1);
      req(1, 0, 1, 16'h0004, 16'h1357, 2'b11, 16'h0000);
      req(1, 1, 0, 16'h0004, 16'h0000, 2'b00, 16'h1357);
      req(1, 1, 0, 16'h0004, 16'h0000, 2'b00, 16'h1357);
      req(1, 1, 0, 16'h0002, 16'h0000, 2'b00, 16'h0F0F); drop(1);
      chk("b_conflict_sticky", {31'd0, b_conflict}, 32'd1);

      repeat (4) @(posedge clk); #1;
      chk("a_queue_drained", qa.size(), 32'd0);
      chk("b_queue_drained", qb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
